// File: rtl/sal_bank_ctrl_pkg.sv
// Shared types and widths for the per-bank DRAM command generator.
// Field widths for the DRAM address, AXI id/len and timing counters live here.
package sal_bk_pkg;

    localparam int DRAM_BA_W = 3;
    localparam int DRAM_RA_W = 16;
    localparam int DRAM_CA_W = 10;
    localparam int AXI_ID_W  = 4;
    localparam int AXI_LEN_W = 8;
    localparam int T_W       = 8;

    typedef enum logic [1:0] {
        ST_CLOSED     = 2'd0,
        ST_OPEN       = 2'd1,
        ST_REFRESHING = 2'd2
    } bank_state_t;

    typedef struct packed {
        logic                 wr;
        logic [AXI_ID_W-1:0]  id;
        logic [DRAM_RA_W-1:0] ra;
        logic [DRAM_CA_W-1:0] ca;
        logic [AXI_LEN_W-1:0] len;
    } held_req_t;

endpackage

// File: rtl/sal_bank_ctrl_if.sv
// Interfaces of the bank controller: request handshake, timing monitor and scheduler commands.
// The controller binds to the slave side of the request and timing interfaces and the master side of the scheduler one.
interface sal_bk_req_if;
    import sal_bk_pkg::*;

    logic                 req_valid;
    logic                 req_wr;
    logic [AXI_ID_W-1:0]  req_id;
    logic [DRAM_RA_W-1:0] req_ra;
    logic [DRAM_CA_W-1:0] req_ca;
    logic [AXI_LEN_W-1:0] req_len;
    logic                 req_ready;

    modport master (
        output req_valid, req_wr, req_id, req_ra, req_ca, req_len,
        input  req_ready
    );
    modport slave (
        input  req_valid, req_wr, req_id, req_ra, req_ca, req_len,
        output req_ready
    );
endinterface

interface sal_timing_if;
    import sal_bk_pkg::*;

    logic [T_W-1:0] t_rcd_m1;
    logic [T_W-1:0] t_rp_m1;
    logic [T_W-1:0] t_ras_m1;
    logic [T_W-1:0] t_rfc_m1;
    logic [T_W-1:0] t_rtp_m1;
    logic [T_W-1:0] t_wtp_m1;

    modport master (output t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1);
    modport slave  (input  t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1);
endinterface

interface sal_sched_if;
    import sal_bk_pkg::*;

    logic                 act_req;
    logic                 rd_req;
    logic                 wr_req;
    logic                 pre_req;
    logic                 ref_req;
    logic                 act_gnt;
    logic                 rd_gnt;
    logic                 wr_gnt;
    logic                 pre_gnt;
    logic                 ref_gnt;
    logic [DRAM_BA_W-1:0] sched_ba;
    logic [DRAM_RA_W-1:0] sched_ra;
    logic [DRAM_CA_W-1:0] sched_ca;
    logic [AXI_ID_W-1:0]  sched_id;
    logic [AXI_LEN_W-1:0] sched_len;

    modport master (
        output act_req, rd_req, wr_req, pre_req, ref_req,
        output sched_ba, sched_ra, sched_ca, sched_id, sched_len,
        input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt
    );
    modport slave (
        input  act_req, rd_req, wr_req, pre_req, ref_req,
        input  sched_ba, sched_ra, sched_ca, sched_id, sched_len,
        output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt
    );
endinterface

// File: rtl/sal_bank_ctrl_tcnt.sv
// Loadable saturating down-counter; is_zero marks the timing constraint as satisfied.
module sal_tcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         is_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank DRAM command generator: holds one request, tracks the open row and
// raises ACT/RD/WR/PRE/REF toward the scheduler once intra-bank timing allows.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_CLOSED     | no row open; may ACT the held request or REF when pending
// ST_OPEN       | open_row active; RD/WR on hit, PRE on miss or refresh
// ST_REFRESHING | refresh granted, waiting for tRFC before returning to CLOSED
module sal_bank_ctrl
    import sal_bk_pkg::*;
#(
    parameter int BK_ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    sal_timing_if.slave tim,
    sal_bk_req_if.slave bk,
    sal_sched_if.master sch,
    input  logic        ref_pend_i,
    output logic        ref_done_o
);

    bank_state_t          state;
    bank_state_t          state_nxt;
    held_req_t            hreq;
    logic                 held;
    logic                 out_of_rst;
    logic [DRAM_RA_W-1:0] open_row;
    logic                 row_hit;

    logic act_r, rd_r, wr_r, pre_r, ref_r;
    logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
    logic rcd_z, rp_z, ras_z, rfc_z, rtp_z, wtp_z;

    // A grant only counts when it answers our own request.
    assign act_fire = act_r & sch.act_gnt;
    assign rd_fire  = rd_r  & sch.rd_gnt;
    assign wr_fire  = wr_r  & sch.wr_gnt;
    assign pre_fire = pre_r & sch.pre_gnt;
    assign ref_fire = ref_r & sch.ref_gnt;

    assign row_hit    = (hreq.ra == open_row);
    assign ref_done_o = ref_fire;

    // A pending refresh blocks new loads; a request already held still completes.
    assign bk.req_ready = out_of_rst & ~held & ~ref_pend_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_rst <= 1'b0;
            held       <= 1'b0;
            hreq       <= '0;
            open_row   <= '0;
        end else begin
            out_of_rst <= 1'b1;
            if (bk.req_valid && bk.req_ready) begin
                held     <= 1'b1;
                hreq.wr  <= bk.req_wr;
                hreq.id  <= bk.req_id;
                hreq.ra  <= bk.req_ra;
                hreq.ca  <= bk.req_ca;
                hreq.len <= bk.req_len;
            end else if (rd_fire || wr_fire) begin
                held <= 1'b0;
            end
            if (act_fire) begin
                open_row <= hreq.ra;
            end
        end
    end

    sal_tcnt #(.W(T_W)) u_rcd (.clk(clk), .rst_n(rst_n), .load(act_fire), .load_val(tim.t_rcd_m1), .is_zero(rcd_z));
    sal_tcnt #(.W(T_W)) u_ras (.clk(clk), .rst_n(rst_n), .load(act_fire), .load_val(tim.t_ras_m1), .is_zero(ras_z));
    sal_tcnt #(.W(T_W)) u_rtp (.clk(clk), .rst_n(rst_n), .load(rd_fire),  .load_val(tim.t_rtp_m1), .is_zero(rtp_z));
    sal_tcnt #(.W(T_W)) u_wtp (.clk(clk), .rst_n(rst_n), .load(wr_fire),  .load_val(tim.t_wtp_m1), .is_zero(wtp_z));
    sal_tcnt #(.W(T_W)) u_rp  (.clk(clk), .rst_n(rst_n), .load(pre_fire), .load_val(tim.t_rp_m1),  .is_zero(rp_z));
    sal_tcnt #(.W(T_W)) u_rfc (.clk(clk), .rst_n(rst_n), .load(ref_fire), .load_val(tim.t_rfc_m1), .is_zero(rfc_z));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLOSED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLOSED: begin
                if (ref_fire) begin
                    state_nxt = ST_REFRESHING;
                end else if (act_fire) begin
                    state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (pre_fire) begin
                    state_nxt = ST_CLOSED;
                end
            end
            ST_REFRESHING: begin
                if (rfc_z) begin
                    state_nxt = ST_CLOSED;
                end
            end
            default: state_nxt = ST_CLOSED;
        endcase
    end

    always_comb begin
        act_r = 1'b0;
        rd_r  = 1'b0;
        wr_r  = 1'b0;
        pre_r = 1'b0;
        ref_r = 1'b0;
        case (state)
            ST_CLOSED: begin
                if (ref_pend_i && !held) begin
                    ref_r = rp_z;
                end else if (held) begin
                    act_r = rp_z & rfc_z;
                end
            end
            ST_OPEN: begin
                if (held && row_hit) begin
                    rd_r = rcd_z & ~hreq.wr;
                    wr_r = rcd_z &  hreq.wr;
                end else if (held || ref_pend_i) begin
                    pre_r = ras_z & rtp_z & wtp_z;
                end
            end
            default: ;
        endcase

        sch.sched_ba  = '0;
        sch.sched_ra  = '0;
        sch.sched_ca  = '0;
        sch.sched_id  = '0;
        sch.sched_len = '0;
        if (act_r || rd_r || wr_r || pre_r || ref_r) begin
            sch.sched_ba = DRAM_BA_W'(BK_ID);
            if (pre_r) begin
                sch.sched_ra = open_row;
            end else if (!ref_r) begin
                sch.sched_ra = hreq.ra;
            end
            if (held) begin
                sch.sched_ca  = hreq.ca;
                sch.sched_id  = hreq.id;
                sch.sched_len = hreq.len;
            end
        end
    end

    assign sch.act_req = act_r;
    assign sch.rd_req  = rd_r;
    assign sch.wr_req  = wr_r;
    assign sch.pre_req = pre_r;
    assign sch.ref_req = ref_r;

endmodule
